// File: rtl/bp_io_cmd_arbiter_router.sv
// N-source to one-sink BedRock IO command arbiter with in-order response steering.
// Define BP_IO_ARB_FIXED_PRIO_EN for fixed priority (lowest index wins) instead of round-robin.
module bp_io_cmd_arbiter_router #(
    parameter  int num_src_p   = 2,
    parameter  int msg_width_p = 128,
    parameter  int track_els_p = 4,
    localparam int lg_src_lp   = $clog2(num_src_p),
    localparam int lg_els_lp   = $clog2(track_els_p),
    localparam int cnt_w_lp    = $clog2(track_els_p + 1)
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic [num_src_p*msg_width_p-1:0] src_cmd_i,
    input  logic [num_src_p-1:0]             src_cmd_v_i,
    output logic [num_src_p-1:0]             src_cmd_yumi_o,
    output logic [msg_width_p-1:0]           src_resp_o,
    output logic [num_src_p-1:0]             src_resp_v_o,
    input  logic [num_src_p-1:0]             src_resp_ready_and_i,
    output logic [msg_width_p-1:0]           io_cmd_o,
    output logic                             io_cmd_v_o,
    input  logic                             io_cmd_ready_and_i,
    input  logic [msg_width_p-1:0]           io_resp_i,
    input  logic                             io_resp_v_i,
    output logic                             io_resp_yumi_o,
    output logic [cnt_w_lp-1:0]              outstanding_o,
    output logic                             err_o
);

    logic [num_src_p-1:0][msg_width_p-1:0] w_src_cmd;
    logic [lg_src_lp-1:0]                  w_arb_grant;
    logic [lg_src_lp-1:0]                  w_grant;
    logic [lg_src_lp-1:0]                  w_head;
    logic                                  w_full;
    logic                                  w_empty;
    logic                                  w_cmd_v;
    logic                                  w_cmd_hs;
    logic                                  w_pop;
    logic                                  w_orphan;

    logic                                  r_lock_v;
    logic [lg_src_lp-1:0]                  r_lock_id;
    logic [lg_src_lp-1:0]                  r_fifo_mem [track_els_p];
    logic [lg_els_lp-1:0]                  r_wr_ptr;
    logic [lg_els_lp-1:0]                  r_rd_ptr;
    logic [cnt_w_lp-1:0]                   r_count;
    logic                                  r_err;

    assign w_src_cmd = src_cmd_i;

`ifdef BP_IO_ARB_FIXED_PRIO_EN
    always_comb begin
        w_arb_grant = '0;
        for (int i = num_src_p - 1; i >= 0; i--)
            if (src_cmd_v_i[i]) w_arb_grant = lg_src_lp'(i);
    end
`else
    localparam logic [lg_src_lp:0] NumSrc = (lg_src_lp + 1)'(num_src_p);

    logic [lg_src_lp-1:0] r_rr_ptr;
    logic [lg_src_lp:0]   w_idx;
    logic                 w_found;

    // Scan from the pointer upward, wrapping; first valid source wins.
    always_comb begin
        w_arb_grant = r_rr_ptr;
        w_found     = 1'b0;
        w_idx       = '0;
        for (int i = 0; i < num_src_p; i++) begin
            w_idx = {1'b0, r_rr_ptr} + (lg_src_lp + 1)'(i);
            if (w_idx >= NumSrc) w_idx = w_idx - NumSrc;
            if (!w_found && src_cmd_v_i[w_idx[lg_src_lp-1:0]]) begin
                w_arb_grant = w_idx[lg_src_lp-1:0];
                w_found     = 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i)
            r_rr_ptr <= '0;
        else if (w_cmd_hs)
            r_rr_ptr <= (w_grant == lg_src_lp'(num_src_p - 1)) ? '0 : w_grant + 1'b1;
    end
`endif

    // A command offered but not yet taken keeps its grant until the handshake.
    assign w_grant  = r_lock_v ? r_lock_id : w_arb_grant;
    assign w_full   = (r_count == cnt_w_lp'(track_els_p));
    assign w_empty  = (r_count == '0);
    assign w_head   = r_fifo_mem[r_rd_ptr];

    // Full blocks issue even if a pop lands this cycle: no resp-to-cmd comb path.
    assign w_cmd_v  = src_cmd_v_i[w_grant] & ~w_full & ~reset_i;
    assign w_cmd_hs = w_cmd_v & io_cmd_ready_and_i;

    assign io_cmd_v_o    = w_cmd_v;
    assign io_cmd_o      = w_src_cmd[w_grant];
    assign src_resp_o    = io_resp_i;
    assign outstanding_o = r_count;
    assign err_o         = r_err;

    always_comb begin
        src_cmd_yumi_o = '0;
        if (w_cmd_hs) src_cmd_yumi_o[w_grant] = 1'b1;
    end

    always_comb begin
        src_resp_v_o   = '0;
        io_resp_yumi_o = 1'b0;
        if (!reset_i) begin
            if (!w_empty) begin
                src_resp_v_o[w_head] = io_resp_v_i;
                io_resp_yumi_o       = io_resp_v_i & src_resp_ready_and_i[w_head];
            end else begin
                io_resp_yumi_o = io_resp_v_i;
            end
        end
    end

    assign w_pop    = io_resp_yumi_o & ~w_empty;
    assign w_orphan = io_resp_v_i & w_empty & ~reset_i;

    always_ff @(posedge clk_i) begin
        if (w_cmd_hs) r_fifo_mem[r_wr_ptr] <= w_grant;
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_lock_v  <= 1'b0;
            r_lock_id <= '0;
            r_err     <= 1'b0;
        end else begin
            if (w_cmd_hs) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)    r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + cnt_w_lp'(w_cmd_hs) - cnt_w_lp'(w_pop);
            if (w_cmd_hs) begin
                r_lock_v <= 1'b0;
            end else if (w_cmd_v) begin
                r_lock_v  <= 1'b1;
                r_lock_id <= w_grant;
            end
            if (w_orphan) r_err <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_io_cmd_arbiter_router.sv
// Randomized scoreboard bench: a queue-based reference model predicts per-cycle outputs
// and command/response transactions; a negedge monitor pops and compares.
module tb_bp_io_cmd_arbiter_router;
    localparam int N  = 3;
    localparam int W  = 128;
    localparam int T  = 4;
    localparam int CW = $clog2(T + 1);

    logic           clk = 1'b0;
    logic           rst;
    logic [N*W-1:0] src_cmd_i;
    logic [N-1:0]   src_cmd_v_i;
    logic [N-1:0]   src_cmd_yumi_o;
    logic [W-1:0]   src_resp_o;
    logic [N-1:0]   src_resp_v_o;
    logic [N-1:0]   src_resp_ready_and_i;
    logic [W-1:0]   io_cmd_o;
    logic           io_cmd_v_o;
    logic           io_cmd_ready_and_i;
    logic [W-1:0]   io_resp_i;
    logic           io_resp_v_i;
    logic           io_resp_yumi_o;
    logic [CW-1:0]  outstanding_o;
    logic           err_o;

    always #5 clk = ~clk;

    bp_io_cmd_arbiter_router #(.num_src_p(N), .msg_width_p(W), .track_els_p(T)) dut (
        .clk_i(clk), .reset_i(rst),
        .src_cmd_i(src_cmd_i), .src_cmd_v_i(src_cmd_v_i), .src_cmd_yumi_o(src_cmd_yumi_o),
        .src_resp_o(src_resp_o), .src_resp_v_o(src_resp_v_o),
        .src_resp_ready_and_i(src_resp_ready_and_i),
        .io_cmd_o(io_cmd_o), .io_cmd_v_o(io_cmd_v_o), .io_cmd_ready_and_i(io_cmd_ready_and_i),
        .io_resp_i(io_resp_i), .io_resp_v_i(io_resp_v_i), .io_resp_yumi_o(io_resp_yumi_o),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    typedef struct {
        logic         v;
        logic [N-1:0] yumi;
        logic [N-1:0] rv;
        logic         ry;
        int           outst;
        logic         err;
    } stat_t;

    typedef struct {
        int           src;
        logic [W-1:0] data;
    } resp_t;

    stat_t        stat_q[$];
    logic [W-1:0] exp_cmd_q[$];
    resp_t        exp_resp_q[$];

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string nm, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, exp);
        end
    endtask

    // Reference model state
    int           m_ptr = 0;
    bit           m_lock_v = 0;
    int           m_lock_id = 0;
    int           m_oq[$];
    bit           m_err = 0;
    logic [N-1:0] sv;
    logic [W-1:0] smsg[N];
    int           seq = 0;

    function automatic int pick(input logic [N-1:0] v, input int p);
`ifdef BP_IO_ARB_FIXED_PRIO_EN
        for (int i = 0; i < N; i++) if (v[i]) return i;
        return 0;
`else
        for (int i = 0; i < N; i++) if (v[(p + i) % N]) return (p + i) % N;
        return p;
`endif
    endfunction

    function automatic logic [W-1:0] new_msg(input int k, input int s);
        return {8'(k), 24'(s), $urandom(), $urandom(), $urandom()};
    endfunction

    // Monitor
    initial begin
        stat_t e;
        resp_t r;
        logic [W-1:0] c;
        forever begin
            @(negedge clk);
            if (!rst && stat_q.size() > 0) begin
                e = stat_q.pop_front();
                chk("io_cmd_v", W'(io_cmd_v_o), W'(e.v));
                chk("src_cmd_yumi", W'(src_cmd_yumi_o), W'(e.yumi));
                chk("src_resp_v", W'(src_resp_v_o), W'(e.rv));
                chk("io_resp_yumi", W'(io_resp_yumi_o), W'(e.ry));
                chk("outstanding", W'(outstanding_o), W'(e.outst));
                chk("err", W'(err_o), W'(e.err));
                if (io_cmd_v_o && io_cmd_ready_and_i) begin
                    if (exp_cmd_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL cmd_unexpected actual=%0h required=none", io_cmd_o);
                    end else begin
                        c = exp_cmd_q.pop_front();
                        chk("io_cmd_data", io_cmd_o, c);
                    end
                end
                if (io_resp_yumi_o && src_resp_v_o != '0) begin
                    if (exp_resp_q.size() == 0) begin
                        checks++; failures++;
                        $display("FAIL resp_unexpected actual=%0h required=none", src_resp_v_o);
                    end else begin
                        r = exp_resp_q.pop_front();
                        chk("resp_route", W'(src_resp_v_o), W'(1) << r.src);
                        chk("resp_data", src_resp_o, r.data);
                    end
                end
            end
        end
    end

    // Stimulus + model
    initial begin
        int g, head, resp_pct;
        bit full, ev, hs, ery, nonempty;
        logic [N-1:0] erv;
        stat_t st;
        resp_t rr;

        rst = 1'b1;
        src_cmd_i = '0; src_cmd_v_i = '0; src_resp_ready_and_i = '0;
        io_cmd_ready_and_i = 1'b0; io_resp_i = '0; io_resp_v_i = 1'b0;
        sv = '0;
        for (int k = 0; k < N; k++) smsg[k] = '0;
        #12;
        chk("rst_cmd_v", W'(io_cmd_v_o), W'(0));
        chk("rst_yumi", W'(src_cmd_yumi_o), W'(0));
        chk("rst_resp_v", W'(src_resp_v_o), W'(0));
        chk("rst_resp_yumi", W'(io_resp_yumi_o), W'(0));
        chk("rst_outstanding", W'(outstanding_o), W'(0));
        chk("rst_err", W'(err_o), W'(0));
        @(negedge clk);
        rst = 1'b0;

        for (int cyc = 0; cyc < 3000; cyc++) begin
            @(posedge clk);
            #1;
            resp_pct = (cyc < 800) ? 50 : (cyc < 1400) ? 5 : 80;
            for (int k = 0; k < N; k++)
                if (!sv[k] && $urandom_range(0, 3) != 0) begin
                    sv[k] = 1'b1;
                    smsg[k] = new_msg(k, seq++);
                end
            src_cmd_v_i = sv;
            for (int k = 0; k < N; k++) src_cmd_i[k*W +: W] = smsg[k];
            io_cmd_ready_and_i = ($urandom_range(0, 3) != 0);
            for (int k = 0; k < N; k++) src_resp_ready_and_i[k] = ($urandom_range(0, 4) != 0);
            io_resp_i = {$urandom(), $urandom(), $urandom(), $urandom()};
            io_resp_v_i = (m_oq.size() > 0) ? ($urandom_range(0, 99) < resp_pct)
                                            : ($urandom_range(0, 29) == 0);

            full = (m_oq.size() == T);
            g    = m_lock_v ? m_lock_id : pick(sv, m_ptr);
            ev   = sv[g] && !full;
            hs   = ev && io_cmd_ready_and_i;
            nonempty = (m_oq.size() > 0);
            erv  = '0;
            if (nonempty) begin
                head = m_oq[0];
                if (io_resp_v_i) erv[head] = 1'b1;
                ery = io_resp_v_i && src_resp_ready_and_i[head];
            end else begin
                head = 0;
                ery = io_resp_v_i;
            end

            st.v = ev; st.yumi = hs ? (N'(1) << g) : '0; st.rv = erv; st.ry = ery;
            st.outst = m_oq.size(); st.err = m_err;
            stat_q.push_back(st);
            if (hs) exp_cmd_q.push_back(smsg[g]);
            if (ery && nonempty) begin
                rr.src = head; rr.data = io_resp_i;
                exp_resp_q.push_back(rr);
            end

            if (hs) begin
                m_ptr = (g + 1) % N;
                m_lock_v = 0;
                sv[g] = 1'b0;
                m_oq.push_back(g);
            end else if (ev) begin
                m_lock_v = 1;
                m_lock_id = g;
            end
            if (ery && nonempty) void'(m_oq.pop_front());
            else if (io_resp_v_i && !nonempty) m_err = 1;
        end

        @(negedge clk);
        #1;
        chk("cmd_q_drained", W'(exp_cmd_q.size()), W'(0));
        chk("resp_q_drained", W'(exp_resp_q.size()), W'(0));
        chk("stat_q_drained", W'(stat_q.size()), W'(0));

        // Async reset mid-cycle with traffic on every input.
        @(posedge clk);
        #1;
        src_cmd_v_i = '1;
        io_cmd_ready_and_i = 1'b1;
        io_resp_v_i = 1'b1;
        src_resp_ready_and_i = '1;
        #2 rst = 1'b1;
        #1;
        chk("arst_cmd_v", W'(io_cmd_v_o), W'(0));
        chk("arst_yumi", W'(src_cmd_yumi_o), W'(0));
        chk("arst_resp_v", W'(src_resp_v_o), W'(0));
        chk("arst_resp_yumi", W'(io_resp_yumi_o), W'(0));
        chk("arst_outstanding", W'(outstanding_o), W'(0));
        chk("arst_err", W'(err_o), W'(0));

        // Orphan response after reset.
        @(negedge clk);
        src_cmd_v_i = '0;
        io_resp_v_i = 1'b1;
        rst = 1'b0;
        #1;
        chk("orphan_yumi", W'(io_resp_yumi_o), W'(1));
        chk("orphan_resp_v", W'(src_resp_v_o), W'(0));
        chk("orphan_err_pre", W'(err_o), W'(0));
        @(posedge clk);
        #1;
        io_resp_v_i = 1'b0;
        chk("orphan_err_set", W'(err_o), W'(1));
        repeat (3) @(posedge clk);
        #1;
        chk("orphan_err_held", W'(err_o), W'(1));
        chk("orphan_outstanding", W'(outstanding_o), W'(0));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
